// File: rtl/aoc_num_stream.sv
// ASCII character stream to decimal integer tokens, with sign, EOL/EOF markers and overflow flags.
// One registered output slot (latency 1); input_ready drops while a token is held and out_ready is low.
module aoc_num_stream #(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_valid,
    input  logic [7:0]       char_in,
    input  logic             input_last,
    output logic             input_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic             out_nonum,
    output logic             out_eol,
    output logic             out_eof,
    output logic             out_ovf,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        NUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_nonum_q, out_nonum_d;
    logic             out_eol_q, out_eol_d;
    logic             out_eof_q, out_eof_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             is_digit;
    logic             is_minus;
    logic             is_nl;
    logic [WIDTH+3:0] acc_ext;

    logic             emit;
    logic [WIDTH-1:0] tok_value;
    logic             tok_nonum;
    logic             tok_eol;
    logic             tok_eof;
    logic             tok_ovf;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + {{(WIDTH-1){1'b0}}, 1'b1}) : mag;
    endfunction

    assign input_ready = (state_q != DONE) && (!out_valid_q || out_ready);
    assign accept      = input_valid && input_ready;
    assign is_digit    = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign is_minus    = (char_in == 8'h2D);
    assign is_nl       = (char_in == 8'h0A);

    // acc*10 + d in four extra bits; ASCII digits carry their value in the low nibble
    assign acc_ext = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                   + {{WIDTH{1'b0}}, char_in[3:0]};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        emit        = 1'b0;
        tok_value   = '0;
        tok_nonum   = 1'b0;
        tok_eol     = 1'b0;
        tok_eof     = 1'b0;
        tok_ovf     = 1'b0;

        out_valid_d = out_valid_q && !out_ready;
        out_value_d = out_value_q;
        out_nonum_d = out_nonum_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            if (is_digit) begin
                acc_d   = acc_ext[WIDTH-1:0];
                ovf_d   = ovf_q | (|acc_ext[WIDTH+3:WIDTH]);
                state_d = NUM;
            end else if (SIGNED_EN && is_minus && (state_q != NUM)) begin
                neg_d   = 1'b1;
                state_d = NEG;
            end else if (is_nl) begin
                emit    = 1'b1;
                tok_eol = 1'b1;
                if (state_q == NUM) begin
                    tok_value = apply_sign(acc_q, neg_q);
                    tok_ovf   = ovf_q;
                end else begin
                    tok_nonum = 1'b1;
                end
                acc_d   = '0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end else begin
                // Separator: terminates a number, drops a dangling sign, else ignored
                if (state_q == NUM) begin
                    emit      = 1'b1;
                    tok_value = apply_sign(acc_q, neg_q);
                    tok_ovf   = ovf_q;
                end
                acc_d   = '0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end

            // Final char: reuse its token if it made one, else flush whatever is pending
            if (input_last) begin
                if (!emit) begin
                    emit = 1'b1;
                    if (state_d == NUM) begin
                        tok_value = apply_sign(acc_d, neg_d);
                        tok_ovf   = ovf_d;
                    end else begin
                        tok_nonum = 1'b1;
                    end
                end
                tok_eof = 1'b1;
                acc_d   = '0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_value_d = tok_value;
            out_nonum_d = tok_nonum;
            out_eol_d   = tok_eol;
            out_eof_d   = tok_eof;
            out_ovf_d   = tok_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_nonum_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_nonum_q <= out_nonum_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_nonum = out_nonum_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_aoc_num_stream.sv
// Bench for aoc_num_stream: three instances (signed W16, unsigned W16, signed W8) share one driver.
module tb_aoc_num_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic [7:0] char_in;
    logic       in_last;
    logic       out_ready;
    int         sel;

    always #5 clk = ~clk;

    logic        rdy0, ov0, nn0, eol0, eof0, ovf0;
    logic [15:0] val0;
    logic        rdy1, ov1, nn1, eol1, eof1, ovf1;
    logic [15:0] val1;
    logic        rdy2, ov2, nn2, eol2, eof2, ovf2;
    logic [7:0]  val2;

    aoc_num_stream #(.WIDTH(16), .SIGNED_EN(1'b1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .input_valid(in_vld && (sel == 0)), .char_in(char_in),
        .input_last(in_last), .input_ready(rdy0), .out_valid(ov0), .out_value(val0),
        .out_nonum(nn0), .out_eol(eol0), .out_eof(eof0), .out_ovf(ovf0), .out_ready(out_ready));

    aoc_num_stream #(.WIDTH(16), .SIGNED_EN(1'b0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .input_valid(in_vld && (sel == 1)), .char_in(char_in),
        .input_last(in_last), .input_ready(rdy1), .out_valid(ov1), .out_value(val1),
        .out_nonum(nn1), .out_eol(eol1), .out_eof(eof1), .out_ovf(ovf1), .out_ready(out_ready));

    aoc_num_stream #(.WIDTH(8), .SIGNED_EN(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .input_valid(in_vld && (sel == 2)), .char_in(char_in),
        .input_last(in_last), .input_ready(rdy2), .out_valid(ov2), .out_value(val2),
        .out_nonum(nn2), .out_eol(eol2), .out_eof(eof2), .out_ovf(ovf2), .out_ready(out_ready));

    logic        m_rdy, m_vld, m_nn, m_eol, m_eof, m_ovf;
    logic [15:0] m_val;

    always_comb begin
        m_rdy = rdy0; m_vld = ov0; m_val = val0;
        m_nn  = nn0;  m_eol = eol0; m_eof = eof0; m_ovf = ovf0;
        if (sel == 1) begin
            m_rdy = rdy1; m_vld = ov1; m_val = val1;
            m_nn  = nn1;  m_eol = eol1; m_eof = eof1; m_ovf = ovf1;
        end else if (sel == 2) begin
            m_rdy = rdy2; m_vld = ov2; m_val = {8'h00, val2};
            m_nn  = nn2;  m_eol = eol2; m_eof = eof2; m_ovf = ovf2;
        end
    end

    typedef struct {
        logic [15:0] val;
        bit          nn;
        bit          eol;
        bit          eof;
        bit          ovf;
    } tok_t;

    typedef struct {
        bit   rst;
        int   sel;
        byte  c;
        bit   last;
        bit   ev;
        tok_t t;
    } vec_t;

    tok_t exp_q[$];
    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic tok_t tk(input logic [15:0] v, input bit nn, input bit eol,
                                input bit eof, input bit ovf);
        tok_t t;
        t.val = v; t.nn = nn; t.eol = eol; t.eof = eof; t.ovf = ovf;
        return t;
    endfunction

    task automatic add(input bit r, input int s, input byte c, input bit last, input bit ev,
                       input logic [15:0] v, input bit nn, input bit eol, input bit eof,
                       input bit ovf);
        vec_t x;
        x.rst = r; x.sel = s; x.c = c; x.last = last; x.ev = ev;
        x.t = tk(v, nn, eol, eof, ovf);
        tbl.push_back(x);
    endtask

    // Scoreboard: compare each token as it is handed off
    always @(negedge clk) begin
        tok_t e;
        #3;
        if (rst_n && m_vld && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_token: got value %0h, expected no token", m_val);
            end else begin
                e = exp_q.pop_front();
                chk("tok_value", {16'h0, m_val}, {16'h0, e.val});
                chk("tok_flags{nonum,eol,eof,ovf}", {28'h0, m_nn, m_eol, m_eof, m_ovf},
                    {28'h0, e.nn, e.eol, e.eof, e.ovf});
            end
        end
    end

    task automatic send(input byte c, input bit last);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 100) begin
            @(negedge clk);
            in_vld  = 1'b1;
            char_in = c;
            in_last = last;
            #1;
            ok = m_rdy;
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        in_vld  = 1'b0;
        in_last = 1'b0;
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: char %0h never accepted, expected acceptance", c);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d tokens outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_vld    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'h0, m_vld}, 32'h0);
        chk({tag, "_out_value"}, {16'h0, m_val}, 32'h0);
        chk({tag, "_out_flags"}, {28'h0, m_nn, m_eol, m_eof, m_ovf}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_last = 1'b0; char_in = 8'h00;
        out_ready = 1'b1; sel = 0;

        // sel 0: signed W16, sel 1: unsigned W16, sel 2: signed W8
        add(1, 0, "1", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "2", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, ",", 0, 1, 16'd12,   0, 0, 0, 0);
        add(0, 0, "3", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "4", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "5", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, 8'h0A, 1, 1, 16'd345, 0, 1, 1, 0);

        add(1, 0, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "7", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, " ", 0, 1, 16'hFFF9, 0, 0, 0, 0);
        add(0, 0, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, 8'h0A, 0, 1, 16'd0,  1, 1, 0, 0);
        add(0, 0, "5", 1, 1, 16'd5,    0, 0, 1, 0);

        add(1, 1, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 1, "7", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 1, " ", 0, 1, 16'd7,    0, 0, 0, 0);
        add(0, 1, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 1, 8'h0A, 0, 1, 16'd0,  1, 1, 0, 0);
        add(0, 1, "5", 1, 1, 16'd5,    0, 0, 1, 0);

        add(1, 0, "1", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, 8'h0A, 0, 1, 16'd1,  0, 1, 0, 0);
        add(0, 0, 8'h0A, 0, 1, 16'd0,  1, 1, 0, 0);
        add(0, 0, "2", 1, 1, 16'd2,    0, 0, 1, 0);

        add(1, 2, "3", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "0", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "0", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, 8'h0A, 0, 1, 16'd44, 0, 1, 0, 1);
        add(0, 2, "2", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "5", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "5", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, 8'h0A, 1, 1, 16'd255, 0, 1, 1, 0);

        add(1, 2, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "3", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "0", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, "0", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 2, ",", 0, 1, 16'hD4,   0, 0, 0, 1);
        add(0, 2, "7", 1, 1, 16'd7,    0, 0, 1, 0);

        add(1, 0, "8", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, ",", 1, 1, 16'd8,    0, 0, 1, 0);

        add(1, 0, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "-", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "3", 0, 0, 16'd0,    0, 0, 0, 0);
        add(0, 0, "x", 0, 1, 16'hFFFD, 0, 0, 0, 0);
        add(0, 0, "-", 1, 1, 16'd0,    1, 0, 1, 0);

        sel = 0;
        do_reset();
        @(negedge clk);
        chk_zero_outputs("reset_state");
        chk("reset_input_ready", {31'h0, m_rdy}, 32'h1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                drain();
                sel = tbl[i].sel;
                do_reset();
            end
            if (tbl[i].ev) exp_q.push_back(tbl[i].t);
            send(tbl[i].c, tbl[i].last);
        end
        drain();

        // After the eof token the block refuses further input
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            char_in = "9";
            #1;
            chk("done_input_ready", {31'h0, m_rdy}, 32'h0);
        end
        @(negedge clk);
        in_vld = 1'b0;

        // Backpressure: "9,8,7" with the consumer stalled after the first token
        sel = 0;
        do_reset();
        exp_q.push_back(tk(16'd9, 0, 0, 0, 0));
        exp_q.push_back(tk(16'd8, 0, 0, 0, 0));
        exp_q.push_back(tk(16'd7, 0, 0, 1, 0));
        send("9", 0);
        send(",", 0);
        send("8", 0);
        out_ready = 1'b0;
        send(",", 0);
        for (int i = 0; i < 5; i++) begin
            in_vld  = 1'b1;
            char_in = "7";
            in_last = 1'b1;
            #1;
            chk("stall_input_ready", {31'h0, m_rdy}, 32'h0);
            chk("stall_out_valid", {31'h0, m_vld}, 32'h1);
            chk("stall_out_value", {16'h0, m_val}, 32'd8);
            @(negedge clk);
        end
        in_vld    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        send("7", 1);
        drain();

        // Reset while a token is held, then while a number is in progress
        sel = 0;
        do_reset();
        out_ready = 1'b0;
        send("3", 0);
        send(",", 0);
        #1;
        chk("held_out_value", {16'h0, m_val}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset_held");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", {31'h0, m_vld}, 32'h0);
        chk("post_reset_ready", {31'h0, m_rdy}, 32'h1);
        send("1", 0);
        send("2", 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset_mid_number");
        rst_n = 1'b1;
        exp_q.push_back(tk(16'd4, 0, 1, 1, 0));
        send("4", 0);
        send(8'h0A, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
